// File: rtl/if_stage.sv
// if_stage: instruction fetch with one outstanding imem request, IF/ID slot and skid buffer.
// Optional misaligned-redirect trap: define IF_MISALIGN_TRAP_EN.
module if_stage #(
    parameter int unsigned          WORD_SIZE = 32,
    parameter int unsigned          ADDR_SIZE = 10,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = 32'h0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req,
    output logic [ADDR_SIZE-1:0] imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    input  logic                 id_stall,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic [WORD_SIZE-1:0] instr,
    output logic [WORD_SIZE-1:0] pc_out,
    output logic                 instr_valid
`ifdef IF_MISALIGN_TRAP_EN
    ,
    output logic                 misalign_err
`endif
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [WORD_SIZE-1:0] NOP  = WORD_SIZE'(32'h0000_0013);
    localparam logic [WORD_SIZE-1:0] STEP = WORD_SIZE'(4);

    typedef struct packed {
        logic                 valid;
        logic [WORD_SIZE-1:0] pc;
        logic [WORD_SIZE-1:0] instr;
    } fetch_slot_t;

    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic [WORD_SIZE-1:0] fetch_pc_q;
    logic [WORD_SIZE-1:0] fetch_pc_d;
    logic [WORD_SIZE-1:0] req_pc_q;
    logic [WORD_SIZE-1:0] req_pc_d;
    logic                 kill_q;
    logic                 kill_d;
    fetch_slot_t          slot_q;
    fetch_slot_t          slot_d;
    fetch_slot_t          skid_q;
    fetch_slot_t          skid_d;

    logic [WORD_SIZE-1:0] target;
    logic                 halt;
    logic                 take_gnt;
    logic                 outstanding;
    fetch_slot_t          resp;

`ifdef IF_MISALIGN_TRAP_EN
    logic misalign_q;
    logic bad_target;

    assign target     = redirect_pc;
    assign bad_target = redirect && (redirect_pc[1:0] != 2'b00);
    assign halt       = misalign_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else if (bad_target) begin
            misalign_q <= 1'b1;
        end
    end

    assign misalign_err = misalign_q;
`else
    assign target = redirect_pc & ~WORD_SIZE'(3);
    assign halt   = 1'b0;
`endif

    assign imem_req = rst
                   && (state_q == S_FETCH)
                   && !skid_q.valid
                   && !redirect
                   && !halt;

    assign imem_addr = fetch_pc_q[ADDR_SIZE+1:2];

    assign take_gnt = imem_req && imem_gnt;

    // A request is still in flight past this edge if WAIT sees no
    // response yet, or a grant lands this cycle.
    assign outstanding = ((state_q == S_WAIT) && !imem_rvalid)
                      || take_gnt;

    assign resp = '{valid: 1'b1, pc: req_pc_q, instr: imem_rdata};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        kill_d     = kill_q;
        slot_d     = slot_q;
        skid_d     = skid_q;

        if (!id_stall) begin
            slot_d.valid = 1'b0;
        end

        if (redirect) begin
            slot_d.valid = 1'b0;
            skid_d.valid = 1'b0;
            fetch_pc_d   = target;
            if (outstanding) begin
                kill_d  = 1'b1;
                state_d = S_WAIT;
            end else begin
                kill_d  = 1'b0;
                state_d = S_FETCH;
            end
        end else begin
            unique case (1'b1)
                state_q == S_FETCH: begin
                    if (take_gnt) begin
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + STEP;
                        state_d    = S_WAIT;
                    end
                end
                state_q == S_WAIT: begin
                    if (imem_rvalid) begin
                        state_d = S_FETCH;
                        if (kill_q) begin
                            kill_d = 1'b0;
                        end else if (!slot_q.valid || !id_stall) begin
                            slot_d = resp;
                        end else begin
                            skid_d  = resp;
                            state_d = S_HOLD;
                        end
                    end
                end
                state_q == S_HOLD: begin
                    if (!id_stall) begin
                        slot_d       = skid_q;
                        skid_d.valid = 1'b0;
                        state_d      = S_FETCH;
                    end
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end

        // A trapped stage never presents an instruction again.
        if (halt) begin
            slot_d.valid = 1'b0;
            skid_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            kill_q     <= 1'b0;
            slot_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            kill_q     <= kill_d;
            slot_q     <= slot_d;
            skid_q     <= skid_d;
        end
    end

    assign instr       = slot_q.valid ? slot_q.instr : NOP;
    assign pc_out      = slot_q.pc;
    assign instr_valid = slot_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed self-checking bench for if_stage.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I0  = 32'h0050_0093;
    localparam logic [31:0] I1  = 32'h00A0_0113;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        id_stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        instr_valid;
`ifdef IF_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    int total = 0;
    int bad = 0;

    if_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_stall    (id_stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .pc_out      (pc_out),
        .instr_valid (instr_valid)
`ifdef IF_MISALIGN_TRAP_EN
        ,
        .misalign_err(misalign_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic reset_dut();
        rst = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        id_stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        imem_gnt = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (imem_req !== 1'b0) begin
            bad++; $display("FAIL rst_req got=%0b want=0", imem_req);
        end
        total++;
        if (instr_valid !== 1'b0) begin
            bad++; $display("FAIL rst_valid got=%0b want=0", instr_valid);
        end
        total++;
        if (instr !== NOP) begin
            bad++; $display("FAIL rst_instr got=%h want=%h", instr, NOP);
        end
        total++;
        if (pc_out !== 32'h0) begin
            bad++; $display("FAIL rst_pc got=%h want=0", pc_out);
        end
`ifdef IF_MISALIGN_TRAP_EN
        total++;
        if (misalign_err !== 1'b0) begin
            bad++; $display("FAIL rst_mis got=%0b want=0", misalign_err);
        end
`endif
    endtask

    task automatic test_basic();
        reset_dut();
        imem_gnt = 1'b1;
        #1;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin
            bad++; $display("FAIL basic_req0 got=%0b/%h want=1/000", imem_req, imem_addr);
        end
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = I0;
        #1;
        total++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL basic_wait got=%0b/%0b want=0/0", imem_req, instr_valid);
        end
        @(negedge clk);
        imem_rvalid = 1'b0; imem_gnt = 1'b1;
        #1;
        total++;
        if (instr_valid !== 1'b1 || instr !== I0 || pc_out !== 32'h0) begin
            bad++; $display("FAIL basic_i0 got=%0b/%h/%h want=1/%h/0", instr_valid, instr, pc_out, I0);
        end
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 10'd1) begin
            bad++; $display("FAIL basic_req1 got=%0b/%h want=1/001", imem_req, imem_addr);
        end
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = I1;
        #1;
        total++;
        if (instr_valid !== 1'b0 || instr !== NOP) begin
            bad++; $display("FAIL basic_gap got=%0b/%h want=0/%h", instr_valid, instr, NOP);
        end
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1;
        total++;
        if (instr_valid !== 1'b1 || instr !== I1 || pc_out !== 32'h4) begin
            bad++; $display("FAIL basic_i1 got=%0b/%h/%h want=1/%h/4", instr_valid, instr, pc_out, I1);
        end
    endtask

    // Leaves the DUT in HOLD with I0 in the slot, I1 in skid, id_stall=1.
    task automatic enter_hold();
        reset_dut();
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = I0;
        @(negedge clk);
        imem_rvalid = 1'b0; id_stall = 1'b1; imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = I1;
        #1;
        total++;
        if (instr !== I0 || pc_out !== 32'h0) begin
            bad++; $display("FAIL hold_pre got=%h/%h want=%h/0", instr, pc_out, I0);
        end
        @(negedge clk);
        imem_rvalid = 1'b0;
    endtask

    task automatic test_stall_skid();
        enter_hold();
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr !== I0 || pc_out !== 32'h0) begin
                bad++; $display("FAIL skid_hold%0d got=%0b/%0b/%h/%h want=0/1/%h/0", i, imem_req, instr_valid, instr, pc_out, I0);
            end
            @(negedge clk);
        end
        id_stall = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b0 || instr !== I0) begin
            bad++; $display("FAIL skid_release got=%0b/%h want=0/%h", imem_req, instr, I0);
        end
        @(negedge clk);
        #1;
        total++;
        if (instr_valid !== 1'b1 || instr !== I1 || pc_out !== 32'h4) begin
            bad++; $display("FAIL skid_out got=%0b/%h/%h want=1/%h/4", instr_valid, instr, pc_out, I1);
        end
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 10'd2) begin
            bad++; $display("FAIL skid_next got=%0b/%h want=1/002", imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_hold();
        enter_hold();
        redirect = 1'b1; redirect_pc = 32'h300;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        total++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 10'h0C0) begin
            bad++; $display("FAIL rdh_next got=%0b/%0b/%h want=0/1/0c0", instr_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_wait();
        reset_dut();
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
        #1;
        total++;
        if (imem_req !== 1'b0) begin
            bad++; $display("FAIL rdw_req got=%0b want=0", imem_req);
        end
        @(negedge clk);
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
            end
            #1;
            total++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                bad++; $display("FAIL rdw_drain%0d got=%0b/%0b want=0/0", i, imem_req, instr_valid);
            end
            @(negedge clk);
        end
        imem_rvalid = 1'b0; imem_gnt = 1'b1;
        #1;
        total++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 10'h040) begin
            bad++; $display("FAIL rdw_refetch got=%0b/%0b/%h want=0/1/040", instr_valid, imem_req, imem_addr);
        end
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0297;
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1;
        total++;
        if (instr_valid !== 1'b1 || instr !== 32'h0000_0297 || pc_out !== 32'h100) begin
            bad++; $display("FAIL rdw_out got=%0b/%h/%h want=1/00000297/100", instr_valid, instr, pc_out);
        end
    endtask

    task automatic test_redirect_rvalid_stall();
        reset_dut();
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = I0;
        @(negedge clk);
        imem_rvalid = 1'b0; id_stall = 1'b1; imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = I1;
        redirect = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        redirect = 1'b0; imem_rvalid = 1'b0;
        #1;
        total++;
        if (instr_valid !== 1'b0 || instr !== NOP) begin
            bad++; $display("FAIL rrs_flush got=%0b/%h want=0/%h", instr_valid, instr, NOP);
        end
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 10'h080) begin
            bad++; $display("FAIL rrs_target got=%0b/%h want=1/080", imem_req, imem_addr);
        end
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = I0; id_stall = 1'b0;
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1;
        total++;
        if (instr_valid !== 1'b1 || pc_out !== 32'h200) begin
            bad++; $display("FAIL rrs_out got=%0b/%h want=1/200", instr_valid, pc_out);
        end
    endtask

    task automatic test_wrap();
        reset_dut();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0; imem_gnt = 1'b1;
        #1;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 10'h3FF) begin
            bad++; $display("FAIL wrap_top got=%0b/%h want=1/3ff", imem_req, imem_addr);
        end
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = I0;
        @(negedge clk);
        imem_rvalid = 1'b0; imem_gnt = 1'b1;
        #1;
        total++;
        if (pc_out !== 32'hFFFF_FFFC || imem_req !== 1'b1 || imem_addr !== 10'h000) begin
            bad++; $display("FAIL wrap_next got=%h/%0b/%h want=fffffffc/1/000", pc_out, imem_req, imem_addr);
        end
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = I1;
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1;
        total++;
        if (instr_valid !== 1'b1 || pc_out !== 32'h0 || instr !== I1) begin
            bad++; $display("FAIL wrap_pc got=%0b/%h/%h want=1/0/%h", instr_valid, pc_out, instr, I1);
        end
    endtask

    task automatic test_reset_midflight();
        reset_dut();
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0; rst = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL rmid_rst got=%0b/%0b want=0/0", imem_req, instr_valid);
        end
        @(negedge clk);
        rst = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0BAD;
        #1;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin
            bad++; $display("FAIL rmid_req got=%0b/%h want=1/000", imem_req, imem_addr);
        end
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1;
        total++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin
            bad++; $display("FAIL rmid_stale got=%0b/%0b want=0/1", instr_valid, imem_req);
        end
    endtask

    task automatic test_misalign();
        reset_dut();
        redirect = 1'b1; redirect_pc = 32'h102;
        #1;
        total++;
        if (imem_req !== 1'b0) begin
            bad++; $display("FAIL mis_req0 got=%0b want=0", imem_req);
        end
        @(negedge clk);
        redirect = 1'b0; imem_gnt = 1'b1;
`ifdef IF_MISALIGN_TRAP_EN
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (misalign_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                bad++; $display("FAIL mis_trap%0d got=%0b/%0b/%0b want=1/0/0", i, misalign_err, imem_req, instr_valid);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        total++;
        if (misalign_err !== 1'b0) begin
            bad++; $display("FAIL mis_clear got=%0b want=0", misalign_err);
        end
`else
        #1;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 10'h040) begin
            bad++; $display("FAIL mis_align got=%0b/%h want=1/040", imem_req, imem_addr);
        end
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = I0;
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1;
        total++;
        if (instr_valid !== 1'b1 || pc_out !== 32'h100) begin
            bad++; $display("FAIL mis_pc got=%0b/%h want=1/100", instr_valid, pc_out);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall_skid();
        test_redirect_hold();
        test_redirect_wait();
        test_redirect_rvalid_stall();
        test_wrap();
        test_reset_midflight();
        test_misalign();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
